rf_write_arbiter: RTL
=====================

# rf_write_arbiter

Shares the register file's single write port (write enable, write address, write data) between two writeback requesters: the ALU writeback path (requester 0) and the load/multi-cycle unit writeback path (requester 1). Grants are fair round-robin with valid/ready handshakes, and each accepted write is registered onto the register-file port one cycle later. The block also keeps a pending-destination scoreboard so the issue stage can stall on registers that have an outstanding write. It sits between the execute/memory writeback stages and the register file.

## Interface
- `DATA_W`, default 32: register data width.
- `ADDR_W`, default 5: register address width; register count = 2**ADDR_W.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a write.
- `req0_addr`  in  ADDR_W  requester 0 destination register.
- `req0_data`  in  DATA_W  requester 0 write data.
- `req0_ready`  out  1  requester 0 write is accepted this cycle (combinational).
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `set_valid`  in  1  issue stage marks a destination as pending.
- `set_addr`  in  ADDR_W  destination register to mark as pending.
- `we3`  out  1  register-file write enable (registered).
- `a3`  out  ADDR_W  register-file write address (registered).
- `wd3`  out  DATA_W  register-file write data (registered).
- `pending`  out  2**ADDR_W  scoreboard; bit i = 1 means register i has an outstanding write (registered).

## Operation
- **Handshake:** a transfer occurs when `reqN_valid && reqN_ready`. `reqN_ready` depends combinationally on both valids and the priority pointer. It never depends on `reqN_ready` of the other requester's output. At most one ready is high per cycle.
- **Arbitration:**
  - Only one requester valid: that requester is granted.
  - Both requesters valid: grant goes to the requester not granted most recently.
  - Neither valid: no grant.
- **Priority pointer `last`:** one flop. Updated only on a transfer, to the granted index. Reset value 1, so requester 0 wins the first contention.
- **Requester obligation:** a requester holds `addr`/`data` stable while `valid && !ready`. The block does not check this.
- **Write stage:** on a transfer, the next cycle drives `we3 = (addr != 0)`, `a3 = addr`, `wd3 = data`.
  - With no transfer, `we3` = 0; `a3` and `wd3` hold their previous values.
  - Writes to register 0 are accepted (ready asserts) but never raise `we3`.
- **Scoreboard:**
  - On `set_valid`, `pending[set_addr]` is set.
  - On a transfer, `pending[addr]` is cleared.
  - If set and clear target the same register in the same cycle, the set wins: the new producer is still outstanding.
  - `pending[0]` is always 0, and `set_valid` with `set_addr = 0` is ignored.
  - A clear of a non-pending register is harmless.
- **No internal buffering:** throughput is one write per cycle total. A losing requester waits with ready low.

## Timing
- **Reset values:** `we3` = 0, `a3` = 0, `wd3` = 0, `pending` = all 0, `last` = 1.
- **Reset mid-operation:** `rst_n` low asynchronously clears every flop. A registered write in flight is dropped (`we3` falls immediately). `reqN_ready` is forced to 0 while `rst_n` is low.
- **Latency:** transfer in cycle T gives `we3`/`a3`/`wd3` valid in cycle T+1. The register file captures the write at the end of T+1. The `pending` bit clears in T+1.
- **Set latency:** `set_valid` in cycle T gives `pending` bit visible in T+1.
- **Continuous contention:** grants alternate every cycle (0,1,0,1,…).

## Structure
- Shared package `rf_pkg` holds:
  - `REG_ADDR_W` = 5, `REG_DATA_W` = 32, `NUM_REGS` = 32.
  - A typedef for register address.
  - A typedef for the write-request bundle (valid, addr, data).
- One sub-module: `rr_arb2`, a two-way round-robin arbiter.
  - Inputs: `clk`, `rst_n`, `req[1:0]`, `advance`.
  - Output: one-hot `gnt[1:0]`.
  - Owns the `last` flop.
- The write-stage register and the scoreboard stay in `rf_write_arbiter`.

## Test plan
- **Reset:** hold `rst_n` = 0, drive both valids high → both readies 0, `we3` = 0, `pending` = 0. Release → `req0_ready` = 1 in the first cycle.
- **Single requester:** `req1_valid` with addr 7, data 0xDEADBEEF for one cycle → `req1_ready` = 1. Next cycle `we3` = 1, `a3` = 7, `wd3` = 0xDEADBEEF. The cycle after, `we3` = 0.
- **Contention:** both valid for 4 cycles with addrs 3 and 4 → grants 0,1,0,1. `a3` sequence 3,4,3,4, each one cycle after its grant.
- **Register 0:** `req0` to addr 0, data 0x1 → `req0_ready` = 1, `we3` stays 0, `pending[0]` stays 0.
- **Scoreboard:**
  - `set_valid` addr 9 → `pending[9]` = 1 next cycle.
  - Later, `set_valid` addr 9 in the same cycle as a `req0` transfer to 9 → `pending[9]` remains 1.
  - A later transfer to 9 with no set → `pending[9]` = 0.
- **Reset mid-write:** transfer to addr 12 in cycle T; assert `rst_n` low during T+1 → `we3` drops to 0 asynchronously, `pending[12]` = 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions: widths, register count and write-request bundle.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic                  valid;
        reg_addr_t             addr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Owns the "last granted" pointer; the pointer
// only moves when the caller reports that the grant was actually used.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_r;

    // Grant selection: a lone requester always wins, a tie goes to the one not served last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_r ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Priority pointer: starts at 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (advance) begin
            last_r <= gnt[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the ALU and load/multi-cycle
// writeback paths, registers the winning write onto the port, and tracks
// which destination registers still have a write outstanding.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic [ADDR_W-1:0]      req0_addr,
    input  logic [DATA_W-1:0]      req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [ADDR_W-1:0]      req1_addr,
    input  logic [DATA_W-1:0]      req1_data,
    output logic                   req1_ready,
    input  logic                   set_valid,
    input  logic [ADDR_W-1:0]      set_addr,
    output logic                   we3,
    output logic [ADDR_W-1:0]      a3,
    output logic [DATA_W-1:0]      wd3,
    output logic [(2**ADDR_W)-1:0] pending
);

    localparam int NUM_R = 2**ADDR_W;

    logic [1:0]        gnt_s;
    logic [1:0]        ready_s;
    logic              xfer_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [NUM_R-1:0]  clr_mask_s;
    logic [NUM_R-1:0]  set_mask_s;
    logic [NUM_R-1:0]  pending_next_s;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .advance (xfer_s),
        .gnt     (gnt_s)
    );

    // Handshake: readies follow the grant but are held low while reset is asserted.
    always_comb begin
        ready_s    = gnt_s & {2{rst_n}};
        xfer_s     = |ready_s;
        req0_ready = ready_s[0];
        req1_ready = ready_s[1];
    end

    // Select the address/data of whichever requester is being accepted.
    always_comb begin
        sel_addr_s = req0_addr;
        sel_data_s = req0_data;
        if (ready_s[1]) begin
            sel_addr_s = req1_addr;
            sel_data_s = req1_data;
        end else begin
            sel_addr_s = req0_addr;
            sel_data_s = req0_data;
        end
    end

    // Write stage: one-cycle registered copy of the accepted write; register 0 never enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3 <= 1'b0;
            a3  <= {ADDR_W{1'b0}};
            wd3 <= {DATA_W{1'b0}};
        end else if (xfer_s) begin
            we3 <= (sel_addr_s != {ADDR_W{1'b0}});
            a3  <= sel_addr_s;
            wd3 <= sel_data_s;
        end else begin
            we3 <= 1'b0;
            a3  <= a3;
            wd3 <= wd3;
        end
    end

    // Scoreboard next state: clear on accepted write, then set on issue so a new producer wins.
    always_comb begin
        clr_mask_s     = xfer_s ? ({{(NUM_R-1){1'b0}}, 1'b1} << sel_addr_s) : {NUM_R{1'b0}};
        set_mask_s     = set_valid ? ({{(NUM_R-1){1'b0}}, 1'b1} << set_addr) : {NUM_R{1'b0}};
        pending_next_s = ((pending & ~clr_mask_s) | set_mask_s) & ~{{(NUM_R-1){1'b0}}, 1'b1};
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= {NUM_R{1'b0}};
        end else begin
            pending <= pending_next_s;
        end
    end

endmodule
